vga_pixel_unpack: RTL and testbench

- Read-side consumer of the VGA line FIFO.
- Pops 32-bit words from the show-ahead FIFO head and unpacks them into one 24-bit RGB pixel per pixel request.
- Supports 8bpp grey, 16bpp RGB565, packed 24bpp and 32bpp modes.
- Sits between vga_fifo (read port) and the video timing / output register stage; flags underrun when the FIFO cannot supply data in time.

---
 rtl/vga_pixel_unpack_if.sv | 34 +++
 rtl/vga_pixel_unpack.sv | 117 +++++++++++
 tb/tb_vga_pixel_unpack.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_unpack_if.sv
// ============================================================================
// Module : vga_pixel_unpack_if
// Brief  : FIFO read port and pixel request/response bundle for the unpacker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_pixel_unpack_if #(
  parameter int DW = 32,
  parameter int CW = 8
);
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic          rreq;
  logic          pix_req;
  logic          pix_vld;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;
  logic          underrun;

  // master = the unpacker; slave = FIFO plus timing generator side
  modport master (
    input  fifo_q, fifo_empty, pix_req,
    output rreq, pix_vld, r, g, b, underrun
  );

  modport slave (
    output fifo_q, fifo_empty, pix_req,
    input  rreq, pix_vld, r, g, b, underrun
  );
endinterface

`default_nettype wire

// File: rtl/vga_pixel_unpack.sv
// ============================================================================
// Module : vga_pixel_unpack
// Brief  : Pops 32-bit show-ahead FIFO words, emits one RGB888 pixel/request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_pixel_unpack #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  wire logic       clk,
  input  wire logic       aclr,
  input  wire logic       sclr,
  input  wire logic [1:0] cd,
  vga_pixel_unpack_if.master bus
);

  localparam logic [1:0] CD_GREY8 = 2'b00;
  localparam logic [1:0] CD_RGB16 = 2'b01;
  localparam logic [1:0] CD_RGB24 = 2'b10;
  localparam logic [1:0] CD_XRGB  = 2'b11;

  logic [1:0]      ph;
  logic [1:0]      ph_nxt;
  logic [23:0]     hold;
  logic [7:0]      byte_sel;
  logic [15:0]     half;
  logic [3*CW-1:0] pix;
  logic            uses_fifo;
  logic            need_pop;
  logic            accept;

  always_comb begin
    byte_sel  = '0;
    half      = ph[0] ? bus.fifo_q[15:0] : bus.fifo_q[DW-1 -: 16];
    pix       = '0;
    uses_fifo = 1'b1;
    need_pop  = 1'b0;
    ph_nxt    = ph;

    case (ph)
      2'd0:    byte_sel = bus.fifo_q[DW-1 -: 8];
      2'd1:    byte_sel = bus.fifo_q[DW-9 -: 8];
      2'd2:    byte_sel = bus.fifo_q[DW-17 -: 8];
      default: byte_sel = bus.fifo_q[7:0];
    endcase

    case (cd)
      CD_GREY8: begin
        pix      = {byte_sel, byte_sel, byte_sel};
        need_pop = (ph == 2'd3);
        ph_nxt   = ph + 2'd1;
      end
      CD_RGB16: begin
        pix      = {half[15:11], half[15:13], half[10:5], half[10:9],
                    half[4:0], half[4:2]};
        need_pop = ph[0];
        ph_nxt   = {1'b0, ~ph[0]};
      end
      CD_RGB24: begin
        // Three words carry four pixels; H keeps the tail of the last pop.
        case (ph)
          2'd0:    pix = bus.fifo_q[DW-1 -: 24];
          2'd1:    pix = {hold[7:0], bus.fifo_q[DW-1 -: 16]};
          2'd2:    pix = {hold[15:0], bus.fifo_q[DW-1 -: 8]};
          default: pix = hold;
        endcase
        uses_fifo = (ph != 2'd3);
        need_pop  = (ph != 2'd3);
        ph_nxt    = ph + 2'd1;
      end
      CD_XRGB: begin
        pix      = bus.fifo_q[23:0];
        need_pop = 1'b1;
        ph_nxt   = 2'd0;
      end
      default: ;
    endcase

    accept   = bus.pix_req & ~(uses_fifo & bus.fifo_empty);
    bus.rreq = accept & need_pop & ~sclr & aclr;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ph           <= 2'd0;
      hold         <= '0;
      bus.pix_vld  <= 1'b0;
      bus.r        <= '0;
      bus.g        <= '0;
      bus.b        <= '0;
      bus.underrun <= 1'b0;
    end else if (sclr) begin
      ph           <= 2'd0;
      hold         <= '0;
      bus.pix_vld  <= 1'b0;
      bus.r        <= '0;
      bus.g        <= '0;
      bus.b        <= '0;
      bus.underrun <= 1'b0;
    end else begin
      bus.pix_vld <= accept;
      if (accept) begin
        {bus.r, bus.g, bus.b} <= pix;
        ph                    <= ph_nxt;
      end
      if (bus.rreq)
        hold <= bus.fifo_q[23:0];
      if (bus.pix_req && !accept)
        bus.underrun <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_unpack.sv
// ============================================================================
// Module : tb_vga_pixel_unpack
// Brief  : Directed self-checking bench for vga_pixel_unpack with a FIFO model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_unpack;

  logic       clk;
  logic       aclr;
  logic       sclr;
  logic [1:0] cd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  int          wr = 0;
  int          rd = 0;

  vga_pixel_unpack_if #(.DW(32), .CW(8)) bus ();

  vga_pixel_unpack #(.DW(32), .CW(8)) dut (
    .clk  (clk),
    .aclr (aclr),
    .sclr (sclr),
    .cd   (cd),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.fifo_q     = mem[rd % 16];
  assign bus.fifo_empty = (rd == wr);

  always @(posedge clk) begin
    if (bus.rreq)
      rd <= rd + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr % 16] = w;
    wr++;
  endtask

  // Request issued at a negedge; rreq checked before the edge, result after it.
  task automatic do_req(input string tag, input logic er, input logic ev,
                        input logic [23:0] ep, input logic eu);
    bus.pix_req = 1'b1;
    #1;
    check({tag, ".rreq"}, {31'd0, bus.rreq}, {31'd0, er});
    @(posedge clk);
    @(negedge clk);
    check({tag, ".vld"}, {31'd0, bus.pix_vld}, {31'd0, ev});
    check({tag, ".pix"}, {8'd0, bus.r, bus.g, bus.b}, {8'd0, ep});
    check({tag, ".urun"}, {31'd0, bus.underrun}, {31'd0, eu});
  endtask

  task automatic idle(input string tag, input logic [23:0] ep);
    bus.pix_req = 1'b0;
    #1;
    check({tag, ".rreq"}, {31'd0, bus.rreq}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".vld"}, {31'd0, bus.pix_vld}, 32'd0);
    check({tag, ".pix"}, {8'd0, bus.r, bus.g, bus.b}, {8'd0, ep});
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.pix_req = 1'b0;
    sclr = 1'b1;
    cd   = m;
    @(posedge clk);
    @(negedge clk);
    sclr = 1'b0;
  endtask

  initial begin
    aclr        = 1'b0;
    sclr        = 1'b0;
    cd          = 2'b00;
    bus.pix_req = 1'b0;

    #3;
    check("rst.vld", {31'd0, bus.pix_vld}, 32'd0);
    check("rst.pix", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
    check("rst.urun", {31'd0, bus.underrun}, 32'd0);
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);

    // 8bpp grey, big-endian bytes, pop on the 4th request
    set_mode(2'b00);
    push(32'h11223344);
    do_req("g8p0", 1'b0, 1'b1, 24'h111111, 1'b0);
    do_req("g8p1", 1'b0, 1'b1, 24'h222222, 1'b0);
    do_req("g8p2", 1'b0, 1'b1, 24'h333333, 1'b0);
    do_req("g8p3", 1'b1, 1'b1, 24'h444444, 1'b0);
    idle("g8idle", 24'h444444);

    // 16bpp RGB565 expansion
    set_mode(2'b01);
    push(32'hF800_07E0);
    do_req("c16p0", 1'b0, 1'b1, 24'hFF0000, 1'b0);
    do_req("c16p1", 1'b1, 1'b1, 24'h00FF00, 1'b0);
    idle("c16idle", 24'h00FF00);

    // 24bpp packed: 4 pixels in 3 words
    set_mode(2'b10);
    push(32'hAABBCC11);
    push(32'h22334455);
    push(32'h66778899);
    do_req("c24p0", 1'b1, 1'b1, 24'hAABBCC, 1'b0);
    do_req("c24p1", 1'b1, 1'b1, 24'h112233, 1'b0);
    do_req("c24p2", 1'b1, 1'b1, 24'h445566, 1'b0);
    do_req("c24p3", 1'b0, 1'b1, 24'h778899, 1'b0);
    idle("c24idle", 24'h778899);

    // 32bpp underrun then recovery; underrun sticky until sclr
    set_mode(2'b11);
    do_req("u32miss", 1'b0, 1'b0, 24'h000000, 1'b1);
    push(32'h00123456);
    do_req("u32hit", 1'b1, 1'b1, 24'h123456, 1'b1);
    idle("u32idle", 24'h123456);
    check("u32sticky", {31'd0, bus.underrun}, 32'd1);
    set_mode(2'b11);
    check("u32clr", {31'd0, bus.underrun}, 32'd0);

    // 24bpp sclr mid-group discards hold and restarts at the FIFO head
    set_mode(2'b10);
    do_req("s24miss", 1'b0, 1'b0, 24'h000000, 1'b1);
    push(32'hAABBCC11);
    push(32'h22334455);
    push(32'h66778899);
    do_req("s24p0", 1'b1, 1'b1, 24'hAABBCC, 1'b1);
    do_req("s24p1", 1'b1, 1'b1, 24'h112233, 1'b1);
    sclr        = 1'b1;
    bus.pix_req = 1'b1;
    #1;
    check("s24.rreq", {31'd0, bus.rreq}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    sclr = 1'b0;
    check("s24.vld", {31'd0, bus.pix_vld}, 32'd0);
    check("s24.pix", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
    check("s24.urun", {31'd0, bus.underrun}, 32'd0);
    do_req("s24new", 1'b1, 1'b1, 24'h667788, 1'b0);
    idle("s24idle", 24'h667788);

    // Asynchronous aclr between clock edges
    set_mode(2'b00);
    push(32'hA1B2C3D4);
    do_req("a8p0", 1'b0, 1'b1, 24'hA1A1A1, 1'b0);
    bus.pix_req = 1'b1;
    @(posedge clk);
    #1;
    check("a8p1.pix", {8'd0, bus.r, bus.g, bus.b}, 32'h00B2B2B2);
    #1;
    aclr = 1'b0;
    #1;
    check("aclr.vld", {31'd0, bus.pix_vld}, 32'd0);
    check("aclr.pix", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
    check("aclr.urun", {31'd0, bus.underrun}, 32'd0);
    check("aclr.rreq", {31'd0, bus.rreq}, 32'd0);
    bus.pix_req = 1'b0;
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
